async_fifo_rd_stream: RTL

//   Read-side drain engine for async_fifo. Sits in the rclk domain and issues rinc
//   to the FIFO read port. Captures rdata one cycle later into a 3-entry skid buffer
//   and presents it downstream as a valid/ready stream.

---
 rtl/async_fifo_rd_stream.sv | 108 ++++++++++
 1 files changed

// File: rtl/async_fifo_rd_stream.sv
// async_fifo_rd_stream: read-side drain engine for async_fifo.
// Issues rinc toward the FIFO read port and captures rdata one cycle later
// into a 3-entry skid buffer. The buffer is presented downstream as a
// valid/ready stream, with burst-end tagging and a delivered-word counter.
module async_fifo_rd_stream #(
   parameter int DATESIZE  = 8,
   parameter int BURST_LEN = 4,
   parameter int CNTW      = 16
) (
   input  logic                i_rclk,
   input  logic                i_r_rst,
   input  logic                i_rempty,
   input  logic [DATESIZE-1:0] i_rdata,
   output logic                o_rinc,
   output logic                o_m_valid,
   input  logic                i_m_ready,
   output logic [DATESIZE-1:0] o_m_data,
   output logic                o_m_last,
   output logic [CNTW-1:0]     o_rd_cnt,
   output logic                o_busy
);

   localparam int IDXW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam logic [IDXW-1:0] IDX_LAST = IDXW'(BURST_LEN - 1);

   logic [DATESIZE-1:0] w_slots [3];
   logic [1:0]          r_wptr;
   logic [1:0]          r_rptr;
   logic [1:0]          r_occ;
   logic                r_pend;
   logic [IDXW-1:0]     r_idx;
   logic [CNTW-1:0]     r_rd_cnt;
   logic [2:0]          w_res;
   logic                w_rinc;
   logic                w_pop;
   logic [DATESIZE-1:0] w_head;

   // Pointer step for the 3-deep ring.
   function automatic logic [1:0] next3(input logic [1:0] p);
      return (p == 2'd2) ? 2'd0 : p + 2'd1;
   endfunction

   // Reservation = buffered words plus the read in flight. A read is only
   // issued when a slot is guaranteed, so the capture never has to stall and
   // m_ready never reaches rinc combinationally.
   assign w_res  = {1'b0, r_occ} + {2'b00, r_pend};
   assign w_rinc = !i_r_rst && !i_rempty && (w_res < 3'd3);
   assign w_pop  = (r_occ != 2'd0) && i_m_ready;

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_slot
         logic [DATESIZE-1:0] r_slot;
         // Capture the FIFO word into this slot when the in-flight read lands here.
         always_ff @(posedge i_rclk or posedge i_r_rst) begin
            if (i_r_rst)
               r_slot <= '0;
            else if (r_pend && (r_wptr == 2'(gi)))
               r_slot <= i_rdata;
         end
         assign w_slots[gi] = r_slot;
      end
   endgenerate

   // Pointers, occupancy, burst position and delivered-word count.
   always_ff @(posedge i_rclk or posedge i_r_rst) begin
      if (i_r_rst) begin
         r_pend   <= 1'b0;
         r_wptr   <= 2'd0;
         r_rptr   <= 2'd0;
         r_occ    <= 2'd0;
         r_idx    <= '0;
         r_rd_cnt <= '0;
      end else begin
         r_pend <= w_rinc;
         if (r_pend)
            r_wptr <= next3(r_wptr);
         if (w_pop) begin
            r_rptr   <= next3(r_rptr);
            r_rd_cnt <= r_rd_cnt + 1'b1;
            r_idx    <= (r_idx == IDX_LAST) ? '0 : r_idx + IDXW'(1);
         end
         case ({r_pend, w_pop})
            2'b10:   r_occ <= r_occ + 2'd1;
            2'b01:   r_occ <= r_occ - 2'd1;
            default: r_occ <= r_occ;
         endcase
      end
   end

   // Head-of-buffer select; no bypass, so a fresh word shows up a cycle after capture.
   always_comb begin
      w_head = w_slots[0];
      case (r_rptr)
         2'd1:    w_head = w_slots[1];
         2'd2:    w_head = w_slots[2];
         default: w_head = w_slots[0];
      endcase
   end

   assign o_rinc    = w_rinc;
   assign o_m_valid = (r_occ != 2'd0);
   assign o_m_data  = w_head;
   assign o_m_last  = o_m_valid && (r_idx == IDX_LAST);
   assign o_rd_cnt  = r_rd_cnt;
   assign o_busy    = (w_res != 3'd0);

endmodule
